ring_johnson_counter: RTL
=========================

// Module: ring_johnson_counter
// PURPOSE
// - Parametrised N-bit shift-register counter. Run-time choice of one-hot ring or twisted-ring (Johnson) sequence.
// - Adds over the fixed 6-stage ring: up/down direction, enable, parallel load, terminal-count flag,
//   and self-correction of illegal states with an error pulse.
// - Used as a sequencer/phase generator feeding decode-free one-hot (ring) or 2N-state (Johnson) enables.
// PARAMETERS
// - N   6   stage count (>=2); ring period N, Johnson period 2N
// PORTS
// - clk       in   1  clock; all state updates on rising edge
// - clr       in   1  reset, synchronous, active-low
// - en        in   1  advance one state this cycle
// - up        in   1  1: shift toward MSB; 0: shift toward LSB
// - mode      in   1  0: ring (one-hot), 1: Johnson
// - load      in   1  parallel load of load_val this cycle
// - load_val  in   N  value for load
// - q         out  N  counter state (registered)
// - tc        out  1  terminal count (combinational): this enabled step wraps to HOME
// - err       out  1  registered 1-cycle pulse: illegal state or illegal load_val corrected
// BEHAVIOUR
// - HOME = {N-1{0},1}. Legal in both modes, so the reset value does not depend on mode.
// - Reset: clk edge with clr=0 -> q=HOME, err=0. Overrides load/en. Reset mid-sequence aborts it immediately.
// - Priority each edge: clr low > load > illegal-state correction > en > hold.
// - Legality (combinational on a value v):
//   ring: popcount(v)==1.
//   Johnson: count of i in [0,N-2] with v[i]!=v[i+1] is <=1 (thermometer from LSB or MSB, incl. all-0/all-1).
// - Advance (en=1, state legal):
//   ring up:      q <= {q[N-2:0], q[N-1]}
//   ring down:    q <= {q[0], q[N-1:1]}
//   Johnson up:   q <= {q[N-2:0], ~q[N-1]}
//   Johnson down: q <= {~q[0], q[N-1:1]}
//   Up and down are exact inverses in each mode.
// - load=1: load_val legal for current mode -> q<=load_val, err<=0.
//   Illegal -> q<=HOME, err<=1. en is ignored on that cycle.
// - load=0 and q illegal for current mode (e.g. after a mode switch or upset):
//   q<=HOME, err<=1 on that edge, regardless of en. Detection and correction in one cycle.
// - err is 0 on every other edge; it is a pulse, not sticky.
// - tc = en & ~load & clr & legal(q) & (next_q == HOME).
//   Once per period: ring up at q=1<<(N-1); ring down at q=2; Johnson up at q=0; Johnson down at q=3.
// - Mode switch is legal at any cycle. If q is legal in the new mode it continues from q;
//   otherwise it is corrected to HOME on the next edge.
// - Latency: q reflects the en/load/correction of an edge immediately after that edge; no pipeline.
// STRUCTURE
// - Shared package: MODE_RING=1'b0, MODE_JOHNSON=1'b1; function home(N).
// - One sub-module: ring_state_check #(N): inputs v and mode, output legal.
//   Instantiated twice: once on q, once on load_val.
// - Next-state mux and q/err registers live in the top module; tc is pure combinational from q/next.
// TESTING
// - Reset: clr=0 for 2 cycles with load=1, en=1 -> q=6'b000001, err=0, tc=0.
// - Ring up, N=6, en=1: 000001,000010,...,100000,000001.
//   tc=1 only in the cycle q=100000; tc then drops with en=0.
// - Johnson down from HOME, 12 steps: 000001,000000,100000,110000,...,111111,...,000011,000001.
//   tc high exactly when q=000011.
// - Illegal recovery: load 6'b000101 in ring mode -> q=000001, err=1 for one cycle.
//   Switch mode=1 at q=000100 (illegal for Johnson) -> next q=000001, err=1 even with en=0.
// - Priority: load=1,en=1,load_val=000111 in Johnson -> q=000111, tc=0, err=0.
//   Same cycle with clr=0 -> q=000001.
// - Reset mid-run: Johnson at q=111000, clr=0 one cycle -> q=000001.
//   Counting resumes 000011 on the next enabled edge after clr=1.

Source files
------------

// File: rtl/ring_johnson_counter_pkg.sv
// Shared constants and helpers for the ring/Johnson shift-register counter.
package ring_johnson_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  // Widest counter the helpers are sized for; callers cast down to their own width.
  localparam int unsigned MaxN = 64;

  // HOME is a single one in the LSB; it is legal in both ring and Johnson modes.
  function automatic logic [MaxN-1:0] home(int unsigned n);
    logic [MaxN-1:0] h;
    h = '0;
    if (n > 0) h[0] = 1'b1;
    return h;
  endfunction

endpackage

// File: rtl/ring_johnson_counter_if.sv
// Control and status bundle between a sequencer master and the counter.
interface ring_johnson_counter_if #(
  parameter int unsigned N = 6
);
  logic         en;
  logic         up;
  logic         mode;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] q;
  logic         tc;
  logic         err;

  modport master (
    output en, up, mode, load, load_val,
    input  q, tc, err
  );

  modport slave (
    input  en, up, mode, load, load_val,
    output q, tc, err
  );
endinterface

// File: rtl/ring_state_check.sv
// Combinational legality check of a value for the selected counter mode.
module ring_state_check
  import ring_johnson_counter_pkg::*;
#(
  parameter int unsigned N = 6
) (
  input  logic [N-1:0] v,
  input  logic         mode,
  output logic         legal
);

  // Bit i set where neighbours v[i] and v[i+1] differ; a Johnson word has at most one.
  logic [N-2:0] edges;
  assign edges = v[N-2:0] ^ v[N-1:1];

  always_comb begin
    legal = 1'b0;
    if (mode == MODE_RING) begin
      legal = ($countones(v) == 1);
    end else begin
      legal = ($countones(edges) <= 1);
    end
  end

endmodule

// File: rtl/ring_johnson_counter.sv
// N-stage one-hot ring / Johnson counter with direction, load, terminal count and self-correction.
module ring_johnson_counter
  import ring_johnson_counter_pkg::*;
#(
  parameter int unsigned N = 6
) (
  input  logic                  clk,
  input  logic                  clr,
  ring_johnson_counter_if.slave bus
);

  localparam logic [N-1:0] Home = N'(home(N));

  logic [N-1:0] q_q, q_d;
  logic         err_q, err_d;
  logic [N-1:0] adv;
  logic         q_legal;
  logic         ld_legal;

  ring_state_check #(.N(N)) u_q_check (
    .v     (q_q),
    .mode  (bus.mode),
    .legal (q_legal)
  );

  ring_state_check #(.N(N)) u_ld_check (
    .v     (bus.load_val),
    .mode  (bus.mode),
    .legal (ld_legal)
  );

  always_comb begin
    adv = q_q;
    unique case ({bus.mode, bus.up})
      {MODE_RING,    1'b1}: adv = {q_q[N-2:0], q_q[N-1]};
      {MODE_RING,    1'b0}: adv = {q_q[0], q_q[N-1:1]};
      {MODE_JOHNSON, 1'b1}: adv = {q_q[N-2:0], ~q_q[N-1]};
      {MODE_JOHNSON, 1'b0}: adv = {~q_q[0], q_q[N-1:1]};
      default:              adv = q_q;
    endcase
  end

  // Priority below reset: load, then correction of an illegal state, then advance.
  always_comb begin
    q_d   = q_q;
    err_d = 1'b0;
    if (bus.load) begin
      if (ld_legal) begin
        q_d = bus.load_val;
      end else begin
        q_d   = Home;
        err_d = 1'b1;
      end
    end else if (!q_legal) begin
      q_d   = Home;
      err_d = 1'b1;
    end else if (bus.en) begin
      q_d = adv;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      q_q   <= Home;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign bus.q   = q_q;
  assign bus.err = err_q;
  assign bus.tc  = bus.en & ~bus.load & clr & q_legal & (adv == Home);

endmodule
